// File: rtl/sync_fifo_flagged_if.sv
// Handshake/status bundle for sync_fifo_flagged: producer/consumer controls plus
// occupancy and error flags. master drives requests, slave is the FIFO.
interface sync_fifo_flagged_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] data_in;
   logic             push;
   logic             pop;
   logic             err_clr;
   logic [WIDTH-1:0] data_out;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic             overflow;
   logic             underflow;

   modport master (
      output data_in, push, pop, err_clr,
      input  data_out, count, full, empty, almost_full, almost_empty,
             overflow, underflow
   );

   modport slave (
      input  data_in, push, pop, err_clr,
      output data_out, count, full, empty, almost_full, almost_empty,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Show-ahead synchronous FIFO with occupancy-derived status flags and sticky
// overflow/underflow errors; async hard clear and synchronous flush.
module sync_fifo_flagged #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter int unsigned AE_THRESH = 2
) (
   input logic                clk,
   input logic                FIFO_clr_n,
   input logic                FIFO_reset_n,
   sync_fifo_flagged_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             overflow_q;
   logic             underflow_q;

   logic full_c;
   logic empty_c;
   logic do_pop_c;
   logic do_push_c;
   logic ovf_evt_c;
   logic unf_evt_c;

   // Accept decisions; a pop on a full FIFO frees the slot the push uses.
   always_comb begin
      full_c    = (count_q == CW'(DEPTH));
      empty_c   = (count_q == CW'(0));
      do_pop_c  = bus.pop && !empty_c;
      do_push_c = bus.push && (!full_c || do_pop_c);
      ovf_evt_c = bus.push && full_c && !do_pop_c;
      unf_evt_c = bus.pop && empty_c;
   end

   always_ff @(posedge clk or negedge FIFO_clr_n) begin
      if (!FIFO_clr_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (!FIFO_reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push_c && !do_pop_c)      count_q <= count_q + CW'(1);
         else if (do_pop_c && !do_push_c) count_q <= count_q - CW'(1);
         // A fresh error wins over a clear in the same cycle.
         overflow_q  <= (overflow_q  && !bus.err_clr) || ovf_evt_c;
         underflow_q <= (underflow_q && !bus.err_clr) || unf_evt_c;
      end
   end

   // Storage is wiped only by the hard clear; a flush keeps the contents.
   always_ff @(posedge clk or negedge FIFO_clr_n) begin
      if (!FIFO_clr_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (FIFO_reset_n && do_push_c) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   assign bus.data_out     = mem[rd_ptr];
   assign bus.count        = count_q;
   assign bus.full         = full_c;
   assign bus.empty        = empty_c;
   assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
   assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed bench for sync_fifo_flagged: queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_sync_fifo_flagged;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AFT   = 14;
   localparam int unsigned AET   = 2;

   logic clk;
   logic FIFO_clr_n;
   logic FIFO_reset_n;

   sync_fifo_flagged_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   sync_fifo_flagged #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET)
   ) dut (
      .clk(clk), .FIFO_clr_n(FIFO_clr_n), .FIFO_reset_n(FIFO_reset_n), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   // Reference model: a queue of words plus the two sticky error bits.
   logic [WIDTH-1:0] q[$];
   bit m_ovf = 0;
   bit m_unf = 0;

   always @(posedge clk or negedge FIFO_clr_n) begin
      if (!FIFO_clr_n || !FIFO_reset_n) begin
         q.delete();
         m_ovf = 0;
         m_unf = 0;
      end else begin
         int  was;
         bit  take_pop, take_push, e_ovf, e_unf;
         was       = q.size();
         take_pop  = bus.pop && (was > 0);
         take_push = bus.push && ((was < int'(DEPTH)) || take_pop);
         e_ovf     = bus.push && !take_push;
         e_unf     = bus.pop && (was == 0);
         if (take_pop)  void'(q.pop_front());
         if (take_push) q.push_back(bus.data_in);
         m_ovf = (m_ovf && !bus.err_clr) || e_ovf;
         m_unf = (m_unf && !bus.err_clr) || e_unf;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_count", 32'(bus.count), 32'(q.size()));
         chk("m_full",  32'(bus.full),  32'(q.size() == int'(DEPTH)));
         chk("m_empty", 32'(bus.empty), 32'(q.size() == 0));
         chk("m_afull", 32'(bus.almost_full),  32'(q.size() >= int'(AFT)));
         chk("m_aempty", 32'(bus.almost_empty), 32'(q.size() <= int'(AET)));
         chk("m_ovf",   32'(bus.overflow),  32'(m_ovf));
         chk("m_unf",   32'(bus.underflow), 32'(m_unf));
         if (q.size() > 0) chk("m_data", 32'(bus.data_out), 32'(q[0]));
      end
   end

   task automatic cyc(input bit p, input bit r, input logic [WIDTH-1:0] d, input bit e);
      bus.push    = p;
      bus.pop     = r;
      bus.data_in = d;
      bus.err_clr = e;
      @(posedge clk);
      #1;
      bus.push    = 1'b0;
      bus.pop     = 1'b0;
      bus.err_clr = 1'b0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_data"},   32'(bus.data_out), 32'h0);
      chk({tag, "_count"},  32'(bus.count), 32'd0);
      chk({tag, "_empty"},  32'(bus.empty), 32'd1);
      chk({tag, "_aempty"}, 32'(bus.almost_empty), 32'd1);
      chk({tag, "_full"},   32'(bus.full), 32'd0);
      chk({tag, "_afull"},  32'(bus.almost_full), 32'd0);
      chk({tag, "_ovf"},    32'(bus.overflow), 32'd0);
      chk({tag, "_unf"},    32'(bus.underflow), 32'd0);
   endtask

   initial begin
      bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0; bus.data_in = '0;
      FIFO_clr_n = 1'b0;
      FIFO_reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk_cleared("rst");
      FIFO_clr_n = 1'b1;
      chk_en = 1;

      // Fill 0x01..0x10; almost_full rises at count 14.
      for (int i = 1; i <= 16; i++) begin
         cyc(1, 0, 8'(i), 0);
         chk("fill_afull", 32'(bus.almost_full), 32'(i >= 14));
      end
      chk("fill_count", 32'(bus.count), 32'd16);
      chk("fill_full",  32'(bus.full), 32'd1);
      chk("fill_head",  32'(bus.data_out), 32'h01);

      // Push into a full FIFO is dropped and flagged.
      cyc(1, 0, 8'hAA, 0);
      chk("ovf_count", 32'(bus.count), 32'd16);
      chk("ovf_flag",  32'(bus.overflow), 32'd1);
      chk("ovf_head",  32'(bus.data_out), 32'h01);
      cyc(1, 0, 8'hAA, 1);
      chk("ovf_clr_race", 32'(bus.overflow), 32'd1);
      cyc(0, 0, 8'h00, 1);
      chk("ovf_cleared", 32'(bus.overflow), 32'd0);

      // Push and pop together while full.
      cyc(1, 1, 8'h77, 0);
      chk("fsim_count", 32'(bus.count), 32'd16);
      chk("fsim_head",  32'(bus.data_out), 32'h02);
      chk("fsim_ovf",   32'(bus.overflow), 32'd0);
      for (int i = 2; i <= 16; i++) cyc(0, 1, 8'h00, 0);
      chk("fsim_tail",  32'(bus.data_out), 32'h77);
      cyc(0, 1, 8'h00, 0);
      chk("drain_empty", 32'(bus.empty), 32'd1);

      // 20 words streamed through, crossing the pointer wrap.
      for (int i = 1; i <= 3; i++) cyc(1, 0, 8'(i), 0);
      for (int k = 4; k <= 20; k++) begin
         chk("wrap_order", 32'(bus.data_out), 32'(k - 3));
         cyc(1, 1, 8'(k), 0);
      end
      for (int k = 18; k <= 20; k++) begin
         chk("wrap_order", 32'(bus.data_out), 32'(k));
         cyc(0, 1, 8'h00, 0);
      end
      chk("wrap_empty", 32'(bus.empty), 32'd1);
      chk("wrap_unf",   32'(bus.underflow), 32'd0);

      // Push and pop together while empty: only the push lands.
      cyc(1, 1, 8'h55, 0);
      chk("unf_count", 32'(bus.count), 32'd1);
      chk("unf_head",  32'(bus.data_out), 32'h55);
      chk("unf_flag",  32'(bus.underflow), 32'd1);

      // Synchronous flush at count 5, with a push in the same cycle.
      for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h60 + i), 0);
      chk("flush_pre", 32'(bus.count), 32'd5);
      FIFO_reset_n = 1'b0;
      cyc(1, 0, 8'hEE, 0);
      FIFO_reset_n = 1'b1;
      chk("flush_count", 32'(bus.count), 32'd0);
      chk("flush_empty", 32'(bus.empty), 32'd1);
      chk("flush_unf",   32'(bus.underflow), 32'd0);

      // Asynchronous clear in the middle of a push stream.
      for (int i = 1; i <= 3; i++) cyc(1, 0, 8'(8'h30 + i), 0);
      bus.push = 1'b1;
      bus.data_in = 8'h34;
      #2;
      FIFO_clr_n = 1'b0;
      #1;
      chk_cleared("clr");
      #1;
      FIFO_clr_n = 1'b1;
      @(posedge clk);
      #1;
      bus.push = 1'b0;
      chk("resume_count", 32'(bus.count), 32'd1);
      chk("resume_head",  32'(bus.data_out), 32'h34);

      @(posedge clk);
      #1;
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
